// File: rtl/counter_pkg.sv
// Shared definitions for the counter scheduler: FSM state encoding and the
// default requester count / counter width.
package counter_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int CW_DEF    = 3;

    // IDLE : waiting for a request, arbitration happens here
    // RUN  : counter advancing for the granted requester
    // DONE : one-cycle completion pulse, then back to IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req : request vector
//   ptr : index of the last served requester; search starts at ptr+1
//   win : one-hot winner (all zero when no request)
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] win
);

    int   idx;
    logic found;

    // Walk the requesters starting just after ptr and wrapping; the
    // previously served index is visited last, giving it lowest priority.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_sched.sv
// Shared counter scheduler: arbitrates N_REQ requesters round-robin and runs
// one shared up-counter from 0 to the winner's terminal count.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   req  : per-requester request level
//   len  : per-requester terminal count, slice i = len[i*CW +: CW]
//   gnt  : registered one-hot grant
//   cnt  : registered shared counter value
//   busy : high in RUN or DONE
//   done : one-cycle completion pulse to the served requester
//
// state   | meaning
// IDLE    | no run active, arbitrate on any request
// RUN     | counting 0..latched len for the granted requester
// DONE    | done pulse for one cycle, gnt and cnt cleared
module counter_sched
    import counter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*CW-1:0] len,
    output logic [N_REQ-1:0]   gnt,
    output logic [CW-1:0]      cnt,
    output logic               busy,
    output logic [N_REQ-1:0]   done
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    len_q, len_d;
    logic [PW-1:0]    idx_q, idx_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] done_q, done_d;

    logic [N_REQ-1:0] win_oh;
    logic [PW-1:0]    win_idx;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_arb (
        .req (req),
        .ptr (ptr_q),
        .win (win_oh)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_oh[i]) win_idx = PW'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        done_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_RUN;
                    gnt_d   = win_oh;
                    len_d   = len[int'(win_idx)*CW +: CW];
                    cnt_d   = '0;
                    idx_d   = win_idx;
                end
            end
            ST_RUN: begin
                // Only the granted request bit matters; others and len are
                // ignored until the run finishes.
                if (!req[idx_q]) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    ptr_d   = idx_q;
                end else if (cnt_q == len_q) begin
                    state_d = ST_DONE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    done_d  = gnt_q;
                    ptr_d   = idx_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= PW'(N_REQ - 1);
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    assign gnt  = gnt_q;
    assign cnt  = cnt_q;
    assign done = done_q;
    assign busy = (state_q == ST_RUN) || (state_q == ST_DONE);

endmodule
